// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage definitions: M-extension ops, MDU FSM states, ALU opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DIV_OVF_NUM = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES    = 32'hFFFF_FFFF;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Integer ALU opcodes, shared with the execute-stage decode
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Divide-family ops all have funct3[2] set
  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

  // Remainder ops take their sign from the dividend rather than from the sign product
  function automatic logic md_is_rem(input md_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/md_sign_conv.sv
// Conditional two's-complement negate of a W-bit value.
// Latency: combinational.
// Backpressure: none.
module md_sign_conv #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  // Negate when asked, otherwise pass through unchanged
  always_comb begin
    result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide, one bit per cycle, special divides resolved at start.
// Latency: 34 cycles busy for normal ops (32 CALC + FIX + DONE), 1 cycle for div-by-zero/overflow.
// Backpressure: none; core stalls on MD_Busy, MD_Start outside IDLE is dropped, MD_Flush aborts.
module mul_div_unit
  import rv32_pkg::*;
#(
  parameter int DWIDTH = XLEN
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic [DWIDTH-1:0] MD_In_A,
  input  logic [DWIDTH-1:0] MD_In_B,
  input  logic [2:0]        MD_OP,
  input  logic              MD_Start,
  input  logic              MD_Flush,
  output logic              MD_Busy,
  output logic              MD_Done,
  output logic [DWIDTH-1:0] MD_Result
);

  localparam int PW = 2 * DWIDTH;

  md_state_e         state_q, state_nxt;
  md_op_e            op_q;
  logic [DWIDTH-1:0] opnd_q;      // multiplicand for multiply, divisor for divide
  logic [PW-1:0]     acc_q;       // {accumulator/remainder, multiplier/quotient}
  logic [5:0]        cnt_q;
  logic              neg_res_q;   // product / quotient sign
  logic              neg_rem_q;   // remainder sign (dividend sign)

  // Start-time decode
  md_op_e            op_in;
  logic              signed_a, signed_b, neg_a, neg_b;
  logic [DWIDTH-1:0] mag_a, mag_b;
  logic              div_by_zero, div_ovf, is_special;
  logic [DWIDTH-1:0] special_res;

  // Iteration datapath
  logic [DWIDTH:0]   mul_sum;
  logic [PW-1:0]     mul_next;
  logic [DWIDTH:0]   div_sh;
  logic              div_ge;
  logic [DWIDTH-1:0] div_hi;
  logic [PW-1:0]     div_next;

  // Sign correction
  logic [PW-1:0]     fix_in, fix_out;
  logic              fix_neg;
  logic [DWIDTH-1:0] fix_sel;

  // Decode operand signedness and the special divide cases from the raw inputs
  always_comb begin
    op_in       = md_op_e'(MD_OP);
    signed_a    = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                  (op_in == OP_DIV)  || (op_in == OP_REM);
    signed_b    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    neg_a       = signed_a & MD_In_A[DWIDTH-1];
    neg_b       = signed_b & MD_In_B[DWIDTH-1];
    div_by_zero = md_is_div(op_in) && (MD_In_B == '0);
    div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (MD_In_A == DIV_OVF_NUM) && (MD_In_B == ALL_ONES);
    is_special  = div_by_zero || div_ovf;
    if (div_by_zero) begin
      special_res = op_in[1] ? MD_In_A : ALL_ONES;
    end else begin
      special_res = op_in[1] ? '0 : DIV_OVF_NUM;
    end
  end

  md_sign_conv #(.W(DWIDTH)) u_conv_a (
    .value  (MD_In_A),
    .negate (neg_a),
    .result (mag_a)
  );

  md_sign_conv #(.W(DWIDTH)) u_conv_b (
    .value  (MD_In_B),
    .negate (neg_b),
    .result (mag_b)
  );

  // One shift-add multiply step and one restoring-divide step per cycle
  always_comb begin
    mul_sum  = {1'b0, acc_q[PW-1:DWIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[DWIDTH-1:1]};
    div_sh   = acc_q[PW-1:DWIDTH-1];
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_hi   = div_ge ? (div_sh[DWIDTH-1:0] - opnd_q) : div_sh[DWIDTH-1:0];
    div_next = {div_hi, acc_q[DWIDTH-2:0], div_ge};
  end

  // Pick the magnitude to correct: full product, or the quotient/remainder word
  always_comb begin
    if (md_is_div(op_q)) begin
      fix_in = {{DWIDTH{1'b0}}, (op_q[1] ? acc_q[PW-1:DWIDTH] : acc_q[DWIDTH-1:0])};
    end else begin
      fix_in = acc_q;
    end
    fix_neg = md_is_rem(op_q) ? neg_rem_q : neg_res_q;
  end

  md_sign_conv #(.W(PW)) u_conv_fix (
    .value  (fix_in),
    .negate (fix_neg),
    .result (fix_out)
  );

  // Select the architectural result word
  always_comb begin
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: fix_sel = fix_out[PW-1:DWIDTH];
      default:                      fix_sel = fix_out[DWIDTH-1:0];
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next-state: flush wins, specials skip straight to DONE
  always_comb begin
    state_nxt = state_q;
    if (MD_Flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (MD_Start) state_nxt = is_special ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_q == 6'd0) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from registered state only
  always_comb begin
    MD_Busy = (state_q != ST_IDLE);
    MD_Done = (state_q == ST_DONE);
  end

  // Datapath: latch operands on accept, iterate in CALC, register result in FIX
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      op_q      <= OP_MUL;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= 6'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      MD_Result <= '0;
    end else if (!MD_Flush) begin
      case (state_q)
        ST_IDLE: begin
          if (MD_Start) begin
            op_q      <= op_in;
            neg_res_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            cnt_q     <= 6'd31;
            opnd_q    <= md_is_div(op_in) ? mag_b : mag_a;
            acc_q     <= {{DWIDTH{1'b0}}, (md_is_div(op_in) ? mag_a : mag_b)};
            if (is_special) begin
              MD_Result <= special_res;
            end
          end
        end
        ST_CALC: begin
          acc_q <= md_is_div(op_q) ? div_next : mul_next;
          if (cnt_q != 6'd0) begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        ST_FIX: begin
          MD_Result <= fix_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M vectors, special cases, flush and reset.
// Latency: checks Done arrival cycle and Busy length per operation.
// Backpressure: stimulus waits for the unit to go idle before each request.
module tb_mul_div_unit;
  import rv32_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic [31:0] MD_In_A = '0;
  logic [31:0] MD_In_B = '0;
  logic [2:0]  MD_OP = '0;
  logic        MD_Start = 1'b0;
  logic        MD_Flush = 1'b0;
  logic        MD_Busy;
  logic        MD_Done;
  logic [31:0] MD_Result;

  mul_div_unit #(.DWIDTH(32)) dut (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .MD_In_A   (MD_In_A),
    .MD_In_B   (MD_In_B),
    .MD_OP     (MD_OP),
    .MD_Start  (MD_Start),
    .MD_Flush  (MD_Flush),
    .MD_Busy   (MD_Busy),
    .MD_Done   (MD_Done),
    .MD_Result (MD_Result)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          start;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   tag_n = 0;

  task automatic chk(input string what, input int tag, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s op#%0d actual=%h required=%h", what, tag, act, req);
    end
  endtask

  // Edge counter used to time Done relative to the request
  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // Monitor: count busy cycles and score every Done against the queue
  initial forever begin
    @(negedge Clk);
    if (MD_Busy) busy_cnt++;
    else busy_cnt = 0;
    if (MD_Done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done result=%h required=no done", MD_Result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", e.tag, MD_Result, e.res);
        chk("done_latency", e.tag, 32'(cyc - e.start), 32'(e.lat));
        chk("busy_cycles", e.tag, 32'(busy_cnt), 32'(e.lat));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d required=finish before limit", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge Clk);
    while ((MD_Busy || sb.size() != 0) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy=%0b pending=%0d required=idle", MD_Busy, sb.size());
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat);
    exp_t e;
    wait_idle();
    MD_OP    = op;
    MD_In_A  = a;
    MD_In_B  = b;
    MD_Start = 1'b1;
    tag_n++;
    e.res   = res;
    e.lat   = lat;
    e.start = cyc;
    e.tag   = tag_n;
    sb.push_back(e);
    @(negedge Clk);
    MD_Start = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_busy", 0, 32'(MD_Busy), 32'd0);
    chk("reset_done", 0, 32'(MD_Done), 32'd0);
    chk("reset_result", 0, MD_Result, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_N = 1'b1;

    // Multiplies
    issue(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    issue(OP_MULHU,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 34);

    // Divides
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    issue(OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    issue(OP_DIVU, 32'd100,       32'd7,         32'd14,        34);
    issue(OP_REMU, 32'd100,       32'd7,         32'd2,         34);
    issue(OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         34);
    issue(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);

    // Special cases resolved at start
    issue(OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    issue(OP_REM,  32'd5,         32'd0,         32'd5,         1);
    issue(OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    issue(OP_REMU, 32'd5,         32'd0,         32'd5,         1);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Start pulsed while busy is ignored
    issue(OP_MUL, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34);
    repeat (5) @(negedge Clk);
    MD_OP    = OP_DIVU;
    MD_In_A  = 32'd1;
    MD_In_B  = 32'd1;
    MD_Start = 1'b1;
    @(negedge Clk);
    MD_Start = 1'b0;
    wait_idle();
    repeat (40) @(negedge Clk);
    chk("ignored_start_busy", 0, 32'(MD_Busy), 32'd0);
    chk("ignored_start_result", 0, MD_Result, 32'h2345_6780);

    // Flush 10 cycles into a divide
    MD_OP    = OP_DIVU;
    MD_In_A  = 32'd100;
    MD_In_B  = 32'd7;
    MD_Start = 1'b1;
    @(negedge Clk);
    MD_Start = 1'b0;
    repeat (9) @(negedge Clk);
    chk("flush_precheck_busy", 0, 32'(MD_Busy), 32'd1);
    MD_Flush = 1'b1;
    @(negedge Clk);
    MD_Flush = 1'b0;
    chk("flush_busy", 0, 32'(MD_Busy), 32'd0);
    chk("flush_done", 0, 32'(MD_Done), 32'd0);
    chk("flush_result", 0, MD_Result, 32'h2345_6780);
    repeat (40) @(negedge Clk);
    chk("flush_result_later", 0, MD_Result, 32'h2345_6780);

    // Flush together with start in IDLE: not accepted
    MD_Start = 1'b1;
    MD_Flush = 1'b1;
    @(negedge Clk);
    MD_Start = 1'b0;
    MD_Flush = 1'b0;
    chk("flush_start_busy", 0, 32'(MD_Busy), 32'd0);

    // Asynchronous reset mid-CALC
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    repeat (10) @(negedge Clk);
    #2;
    Reset_N = 1'b0;
    sb.delete();
    #1;
    chk("async_reset_busy", 0, 32'(MD_Busy), 32'd0);
    chk("async_reset_done", 0, 32'(MD_Done), 32'd0);
    chk("async_reset_result", 0, MD_Result, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_N = 1'b1;
    issue(OP_MUL, 32'd3, 32'd4, 32'd12, 34);
    wait_idle();
    repeat (3) @(negedge Clk);
    chk("scoreboard_empty", 0, 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
